// File: rtl/count_monitor_if.sv
// Snapshot output stream of count_monitor: valid/ready handshake carrying {epoch, count}.
interface count_monitor_if #(
  parameter int unsigned EPOCH_W = 5
);
  localparam int unsigned DATA_W = EPOCH_W + 3;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/count_monitor.sv
// Watches a free-running 3-bit counter, tracks wraps in an epoch counter and queues
// {epoch, count} snapshots (on capture request or wrap) in a small registered FIFO.
module count_monitor #(
  parameter int unsigned DEPTH   = 4,   // power of two, at least 2
  parameter int unsigned EPOCH_W = 5
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [2:0]              count,
  input  logic                    cap,
  count_monitor_if.master         out_bus,
  output logic                    wrap_pulse,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int unsigned DATA_W = EPOCH_W + 3;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;

  logic [2:0]         prev_count;
  logic [EPOCH_W-1:0] epoch;
  logic [EPOCH_W-1:0] epoch_next;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_next;
  logic [LVL_W-1:0]   kept;
  logic [LVL_W-1:0]   level_next;
  logic [DATA_W-1:0]  push_data;
  logic [DATA_W-1:0]  head_next;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic               wrap_c;
  logic               restart_c;
  logic               push_c;
  logic               pop_c;
  logic               full_c;
  logic               accept_c;

  // Event detection, epoch update and FIFO next-state
  always_comb begin
    wrap_c    = (prev_count == 3'd7) && (count == 3'd0);
    restart_c = (count == 3'd0) && (prev_count != 3'd0) && (prev_count != 3'd7);

    epoch_next = epoch;
    if (wrap_c) begin
      epoch_next = epoch + EPOCH_W'(1);
    end else if (restart_c) begin
      epoch_next = '0;
    end

    push_data = {epoch_next, count};
    push_c    = cap || wrap_c;
    pop_c     = out_bus.out_valid && out_bus.out_ready;
    full_c    = (level == LVL_W'(DEPTH));
    // A full FIFO still takes a push when the head leaves on the same edge
    accept_c  = push_c && (!full_c || pop_c);

    kept        = level - LVL_W'(pop_c);
    level_next  = kept + LVL_W'(accept_c);
    rd_ptr_next = rd_ptr + PTR_W'(pop_c);
    wr_ptr_next = wr_ptr + PTR_W'(accept_c);

    // Head seen after this edge: the incoming entry only if nothing older remains
    head_next = '0;
    if (level_next != '0) begin
      head_next = (kept == '0) ? push_data : mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      prev_count        <= '0;
      epoch             <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      level             <= '0;
      out_bus.out_valid <= 1'b0;
      out_bus.out_data  <= '0;
      wrap_pulse        <= 1'b0;
      overflow          <= 1'b0;
    end else begin
      prev_count        <= count;
      epoch             <= epoch_next;
      wr_ptr            <= wr_ptr_next;
      rd_ptr            <= rd_ptr_next;
      level             <= level_next;
      out_bus.out_valid <= (level_next != '0);
      out_bus.out_data  <= head_next;
      wrap_pulse        <= wrap_c;
      if (push_c && full_c && !pop_c) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage is never read past the pointers, so it needs no reset
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem[wr_ptr] <= push_data;
    end
  end
endmodule

// File: tb/tb_count_monitor.sv
// Self-checking bench for count_monitor: reference model feeds a scoreboard queue,
// a negedge monitor compares every popped entry, scenario tasks check flags inline.
module tb_count_monitor;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned EPOCH_W = 5;
  localparam int unsigned DATA_W  = EPOCH_W + 3;
  localparam int unsigned LVL_W   = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             res = 1'b1;
  logic [2:0]       count = 3'd0;
  logic             cap = 1'b0;
  logic             wrap_pulse;
  logic             overflow;
  logic [LVL_W-1:0] level;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [2:0]         m_prev;
  logic [EPOCH_W-1:0] m_epoch;
  int                 m_level;
  logic [DATA_W-1:0]  sb[$];

  count_monitor_if #(.EPOCH_W(EPOCH_W)) bus ();

  count_monitor #(.DEPTH(DEPTH), .EPOCH_W(EPOCH_W)) dut (
    .clk(clk), .res(res), .count(count), .cap(cap), .out_bus(bus),
    .wrap_pulse(wrap_pulse), .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  // Scoreboard: compare each accepted head with the oldest expected entry
  always @(negedge clk) begin
    logic [DATA_W-1:0] exp_d;
    if (res && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL pop_unexpected: got %h want no entry", bus.out_data);
      end else begin
        exp_d = sb.pop_front();
        if (bus.out_data !== exp_d) $display("FAIL pop_data: got %h want %h", bus.out_data, exp_d);
        else passed++;
      end
    end
  end

  // Drive one cycle of inputs, advance the model, then wait past the edge
  task automatic step(input logic [2:0] c, input logic cp, input logic rdy);
    logic wrap, restart, pop, push;
    logic [EPOCH_W-1:0] en;
    count = c; cap = cp; bus.out_ready = rdy;
    wrap    = (m_prev == 3'd7) && (c == 3'd0);
    restart = (c == 3'd0) && (m_prev != 3'd0) && (m_prev != 3'd7);
    if (wrap) en = EPOCH_W'(m_epoch + 1);
    else if (restart) en = '0;
    else en = m_epoch;
    pop  = (m_level > 0) && rdy;
    push = cp || wrap;
    if (push && (m_level < int'(DEPTH) || pop)) begin
      sb.push_back({en, c});
      m_level++;
    end
    if (pop) m_level--;
    m_prev = c; m_epoch = en;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    res = 1'b0; count = 3'd0; cap = 1'b0; bus.out_ready = 1'b0;
    sb.delete(); m_prev = 3'd0; m_epoch = '0; m_level = 0;
    repeat (2) @(posedge clk);
    #1 res = 1'b1;
  endtask

  task automatic drain(input logic [2:0] c);
    for (int i = 0; i < 3 * int'(DEPTH) && bus.out_valid; i++) step(c, 1'b0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0 || level !== '0 || bus.out_data !== '0)
      $display("FAIL drain_empty: got valid=%b level=%0d data=%h want 0 0 00", bus.out_valid, level, bus.out_data);
    else passed++;
  endtask

  task automatic test_reset();
    #1 res = 1'b0;
    #3;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.out_data !== '0) $display("FAIL reset_data: got %h want 00", bus.out_data); else passed++;
    checks++; if (level !== '0) $display("FAIL reset_level: got %0d want 0", level); else passed++;
    checks++; if (wrap_pulse !== 1'b0) $display("FAIL reset_wrap: got %b want 0", wrap_pulse); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else passed++;
    do_reset();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) step(3'(i), 1'b0, 1'b0);
    step(3'd0, 1'b0, 1'b0);
    checks++; if (wrap_pulse !== 1'b1) $display("FAIL wrap_pulse: got %b want 1", wrap_pulse); else passed++;
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL wrap_valid: got %b want 1", bus.out_valid); else passed++;
    checks++; if (bus.out_data !== 8'h08) $display("FAIL wrap_data: got %h want 08", bus.out_data); else passed++;
    checks++; if (level !== LVL_W'(1)) $display("FAIL wrap_level: got %0d want 1", level); else passed++;
    step(3'd0, 1'b0, 1'b0);
    checks++; if (wrap_pulse !== 1'b0) $display("FAIL wrap_pulse_len: got %b want 0", wrap_pulse); else passed++;
    drain(3'd0);
  endtask

  task automatic test_overflow();
    int exp_lvl;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(3'd3, 1'b1, 1'b0);
      exp_lvl = (i < 4) ? i + 1 : 4;
      checks++; if (level !== LVL_W'(exp_lvl)) $display("FAIL ovf_level[%0d]: got %0d want %0d", i, level, exp_lvl); else passed++;
      checks++; if (overflow !== (i >= 4)) $display("FAIL ovf_flag[%0d]: got %b want %b", i, overflow, (i >= 4)); else passed++;
    end
    checks++; if (bus.out_data !== 8'h03) $display("FAIL ovf_head: got %h want 03", bus.out_data); else passed++;
    drain(3'd3);
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else passed++;
  endtask

  task automatic test_no_bypass();
    do_reset();
    step(3'd2, 1'b1, 1'b1);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h02 || level !== LVL_W'(1))
      $display("FAIL nobypass_head: got valid=%b data=%h level=%0d want 1 02 1", bus.out_valid, bus.out_data, level);
    else passed++;
    step(3'd2, 1'b0, 1'b1);
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0)
      $display("FAIL nobypass_empty: got valid=%b data=%h want 0 00", bus.out_valid, bus.out_data);
    else passed++;
  endtask

  task automatic test_full_pushpop();
    do_reset();
    for (int i = 1; i <= 4; i++) step(3'(i), 1'b1, 1'b0);
    checks++; if (level !== LVL_W'(4)) $display("FAIL full_level: got %0d want 4", level); else passed++;
    for (int i = 0; i < 4; i++) begin
      step((i % 2 == 0) ? 3'd5 : 3'd6, 1'b1, 1'b1);
      checks++; if (level !== LVL_W'(4)) $display("FAIL pushpop_level[%0d]: got %0d want 4", i, level); else passed++;
      checks++; if (overflow !== 1'b0) $display("FAIL pushpop_ovf[%0d]: got %b want 0", i, overflow); else passed++;
    end
    drain(3'd6);
  endtask

  task automatic test_restart();
    do_reset();
    for (int i = 0; i < 8; i++) step(3'(i), 1'b0, 1'b0);
    step(3'd0, 1'b0, 1'b0);
    drain(3'd0);
    step(3'd5, 1'b0, 1'b0);
    step(3'd0, 1'b0, 1'b0);
    checks++; if (wrap_pulse !== 1'b0) $display("FAIL restart_wrap: got %b want 0", wrap_pulse); else passed++;
    checks++; if (level !== '0 || bus.out_valid !== 1'b0)
      $display("FAIL restart_push: got level=%0d valid=%b want 0 0", level, bus.out_valid);
    else passed++;
    for (int i = 1; i < 8; i++) step(3'(i), 1'b0, 1'b0);
    step(3'd0, 1'b0, 1'b0);
    checks++; if (bus.out_data !== 8'h08) $display("FAIL restart_epoch: got %h want 08", bus.out_data); else passed++;
    checks++; if (wrap_pulse !== 1'b1) $display("FAIL restart_next_wrap: got %b want 1", wrap_pulse); else passed++;
    drain(3'd0);
  endtask

  task automatic test_epoch_rollover();
    do_reset();
    for (int w = 0; w < 32; w++) begin
      for (int i = 1; i < 8; i++) step(3'(i), 1'b0, 1'b1);
      step(3'd0, 1'b0, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== {EPOCH_W'(w + 1), 3'd0})
        $display("FAIL epoch_head[%0d]: got valid=%b data=%h want 1 %h", w, bus.out_valid, bus.out_data, {EPOCH_W'(w + 1), 3'd0});
      else passed++;
    end
    step(3'd1, 1'b0, 1'b1);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL epoch_drained: got %b want 0", bus.out_valid); else passed++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) step(3'd6, 1'b1, 1'b0);
    step(3'd6, 1'b0, 1'b1);
    step(3'd7, 1'b0, 1'b1);
    step(3'd0, 1'b0, 1'b0);
    checks++; if (level !== LVL_W'(3) || overflow !== 1'b1 || wrap_pulse !== 1'b1)
      $display("FAIL midrst_pre: got level=%0d ovf=%b wrap=%b want 3 1 1", level, overflow, wrap_pulse);
    else passed++;
    #2 res = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if (level !== '0) $display("FAIL midrst_level: got %0d want 0", level); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL midrst_ovf: got %b want 0", overflow); else passed++;
    checks++; if (wrap_pulse !== 1'b0) $display("FAIL midrst_wrap: got %b want 0", wrap_pulse); else passed++;
    checks++; if (bus.out_data !== '0) $display("FAIL midrst_data: got %h want 00", bus.out_data); else passed++;
    count = 3'd0; cap = 1'b0; bus.out_ready = 1'b0;
    sb.delete(); m_prev = 3'd0; m_epoch = '0; m_level = 0;
    @(posedge clk); #1 res = 1'b1;
    step(3'd0, 1'b0, 1'b1);
    step(3'd0, 1'b0, 1'b1);
    checks++; if (bus.out_valid !== 1'b0 || level !== '0)
      $display("FAIL midrst_discard: got valid=%b level=%0d want 0 0", bus.out_valid, level);
    else passed++;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_wrap();
    test_overflow();
    test_no_bypass();
    test_full_pushpop();
    test_restart();
    test_epoch_rollover();
    test_mid_reset();
    checks++; if (sb.size() != 0) $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 The block SHALL sit directly downstream of the 3-bit synchronous counter and consume its count output.
REQ-002 Parameter DEPTH, default 4, SHALL set the snapshot FIFO entry count, restricted to a power of two.
REQ-003 Parameter EPOCH_W, default 5, SHALL set the epoch (wrap) counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port res, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port count, input, 3 bits: the upstream counter value, sampled on the rising edge of clk.
REQ-007 The block SHALL have port cap, input, 1 bit: capture request, taking one snapshot per cycle high.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the FIFO head is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the head.
REQ-010 The block SHALL have port out_data, output, EPOCH_W+3 bits: the FIFO head as {epoch, count}.
REQ-011 The block SHALL have port wrap_pulse, output, 1 bit: a one-cycle pulse per detected wrap.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag meaning a push was dropped.
REQ-013 The block SHALL have port level, output, clog2(DEPTH)+1 bits: FIFO occupancy, 0..DEPTH.

Function
REQ-014 prev_count SHALL register count every cycle.
REQ-015 A wrap event SHALL be prev_count==7 && count==0, evaluated at the clock edge.
REQ-016 A restart event SHALL be count==0 && prev_count not in {0,7}, meaning the upstream counter was reset.
REQ-017 epoch_next SHALL be epoch+1 on wrap, modulo 2^EPOCH_W with 31->0 wrap-around, 0 on restart, and epoch otherwise.
REQ-018 epoch SHALL register epoch_next.
REQ-019 wrap_pulse SHALL be 1 in the cycle after a wrap edge and 0 otherwise, and SHALL be 0 for restart.
REQ-020 A push SHALL occur when cap || wrap, with at most one entry per edge even when both are true.
REQ-021 Push data SHALL be {epoch_next, count} as sampled at that edge.
REQ-022 A pushed entry SHALL be visible at out_data/out_valid one cycle after the push edge (latency 1).
REQ-023 A pop SHALL occur when out_valid && out_ready at the edge, and the next entry SHALL be presented the following cycle.
REQ-024 Entry order SHALL be strict FIFO.
REQ-025 Full with push and no pop: the entry SHALL be dropped, stored data left unchanged, level held at DEPTH, and overflow set to 1 until reset.
REQ-026 Full with push and pop on the same edge: both SHALL be accepted and level SHALL stay DEPTH, with no overflow.
REQ-027 Empty with push and out_ready high: there SHALL be no bypass, and the entry SHALL appear next cycle.
REQ-028 Pop while empty SHALL be ignored.
REQ-029 out_data SHALL be all zeros whenever out_valid is 0.
REQ-030 level SHALL be registered and SHALL equal the number of stored entries.
REQ-031 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-032 On res==0, state SHALL clear immediately without a clock edge: prev_count=0, epoch=0, FIFO pointers=0, level=0, out_valid=0, out_data=0, wrap_pulse=0, overflow=0.
REQ-033 Assertion of res mid-operation SHALL discard all FIFO contents.
REQ-034 The first edge after res deasserts SHALL NOT report a restart when count==0, because prev_count==0.
REQ-035 res SHALL deassert while cap==0, so no push is lost in the release cycle.

Verification
REQ-036 The bench SHALL cover: reset, then count 0..7,0 with out_ready=0 -> the cycle after the 7->0 edge has wrap_pulse=1, out_valid=1, out_data=8'h08, level=1.
REQ-037 The bench SHALL cover: cap=1 for 6 cycles with out_ready=0 and count steady at 3 -> level 1,2,3,4,4,4; overflow=1 after the 5th push; head still 8'h03.
REQ-038 The bench SHALL cover: FIFO full, cap=1, out_ready=1 on the same edge -> level stays 4, overflow stays 0, entries pop in push order.
REQ-039 The bench SHALL cover: count 5 then 0 (upstream reset), cap=0 -> no push, wrap_pulse=0, epoch 0 (the next wrap yields out_data=8'h08).
REQ-040 The bench SHALL cover: 32 consecutive wraps with out_ready=1 -> popped epochs 1..31, then 0.
REQ-041 The bench SHALL cover: res to 0 mid-clock with level=3 and overflow=1 -> out_valid, level, overflow and wrap_pulse all 0 before the next rising edge.
